reg_write_sequencer: RTL and testbench

Write-side front end for the 16×16 register file. It accepts byte-masked result writes from the data path (D_Bus source) and full-word pointer updates from the address unit (D_Addr source). It serialises them onto the register file's single prioritised write port (upper byte, then lower byte, then address write), so that no write is ever silently dropped by that port's priority chain. Outputs are registered and connect directly to the register file's write strobes, addresses and buses.

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_fifo.sv | 65 ++++++
 rtl/reg_write_sequencer.sv | 150 +++++++++++++++
 tb/tb_reg_write_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared widths and types for the register-file write sequencer.
package wb_pkg;

   localparam int REG_ADDR_W = 4;
   localparam int DATA_W     = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      LOWER = 1'b1
   } state_t;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } a_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of address-unit writes with a fall-through head.
// With WB_HAZARD_EN defined it also exposes per-entry valid/addr for hazard compares.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int A_DEPTH = 2
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  logic     pop,
   input  a_entry_t push_entry,
   output logic     full,
   output logic     empty,
   output a_entry_t head
`ifdef WB_HAZARD_EN
   ,
   output logic [A_DEPTH-1:0]                 ent_valid,
   output logic [A_DEPTH-1:0][REG_ADDR_W-1:0] ent_addr
`endif
);

   localparam int PTR_W = $clog2(A_DEPTH);

   a_entry_t         mem_q [A_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == (PTR_W+1)'(A_DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      end
   end

   // Storage needs no reset: the pointers alone define which slots are live.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_entry;
   end

`ifdef WB_HAZARD_EN
   // A slot is live when its distance from the read pointer is below the count.
   for (genvar gi = 0; gi < A_DEPTH; gi++) begin : g_ent
      logic [PTR_W-1:0] offs;
      assign offs          = PTR_W'(gi) - rd_ptr_q;
      assign ent_valid[gi] = ({1'b0, offs} < count_q);
      assign ent_addr[gi]  = mem_q[gi].addr;
   end
`endif

endmodule

// File: rtl/reg_write_sequencer.sv
// Serialises data-path byte writes and address-unit word writes onto one register-file write port.
// Optional WB_HAZARD_EN adds the hz_addr/hz_pending outstanding-write query.
module reg_write_sequencer
   import wb_pkg::*;
#(
   parameter int A_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  d_valid,
   output logic                  d_ready,
   input  logic [REG_ADDR_W-1:0] d_addr,
   input  logic [1:0]            d_mask,
   input  logic [DATA_W-1:0]     d_data,
   input  logic                  a_valid,
   output logic                  a_ready,
   input  logic [REG_ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0]     a_data,
   output logic                  reg3_writeu,
   output logic                  reg3_writel,
   output logic [REG_ADDR_W-1:0] reg3_addr,
   output logic [DATA_W-1:0]     reg3_bus,
   output logic                  reg4_write,
   output logic [REG_ADDR_W-1:0] reg4_addr,
   output logic [DATA_W-1:0]     reg4_bus
`ifdef WB_HAZARD_EN
   ,
   input  logic [REG_ADDR_W-1:0] hz_addr,
   output logic                  hz_pending
`endif
);

   state_t                state_q, state_d;
   logic                  writeu_q, writeu_d;
   logic                  writel_q, writel_d;
   logic                  reg4_write_q, reg4_write_d;
   logic [REG_ADDR_W-1:0] reg3_addr_q, reg3_addr_d;
   logic [DATA_W-1:0]     reg3_bus_q, reg3_bus_d;
   logic [REG_ADDR_W-1:0] reg4_addr_q, reg4_addr_d;
   logic [DATA_W-1:0]     reg4_bus_q, reg4_bus_d;
   logic                  fifo_full, fifo_empty, fifo_pop;
   a_entry_t              fifo_head;
`ifdef WB_HAZARD_EN
   logic [A_DEPTH-1:0]                 ent_valid;
   logic [A_DEPTH-1:0][REG_ADDR_W-1:0] ent_addr;
   logic [A_DEPTH-1:0]                 fifo_hit;
`endif

   wb_fifo #(.A_DEPTH(A_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (a_valid),
      .pop        (fifo_pop),
      .push_entry ('{addr: a_addr, data: a_data}),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .head       (fifo_head)
`ifdef WB_HAZARD_EN
      ,
      .ent_valid  (ent_valid),
      .ent_addr   (ent_addr)
`endif
   );

   assign a_ready = !fifo_full;

   // The LOWER byte reuses reg3_addr/reg3_bus, which still hold the upper-byte request.
   always_comb begin
      state_d      = state_q;
      writeu_d     = 1'b0;
      writel_d     = 1'b0;
      reg4_write_d = 1'b0;
      reg3_addr_d  = reg3_addr_q;
      reg3_bus_d   = reg3_bus_q;
      reg4_addr_d  = reg4_addr_q;
      reg4_bus_d   = reg4_bus_q;
      d_ready      = 1'b0;
      fifo_pop     = 1'b0;
      if (state_q == LOWER) begin
         writel_d = 1'b1;
         state_d  = IDLE;
      end else if (fifo_full) begin
         reg4_write_d = 1'b1;
         reg4_addr_d  = fifo_head.addr;
         reg4_bus_d   = fifo_head.data;
         fifo_pop     = 1'b1;
      end else if (d_valid) begin
         d_ready = 1'b1;
         if (d_mask != 2'b00) begin
            reg3_addr_d = d_addr;
            reg3_bus_d  = d_data;
         end
         case (d_mask)
            2'b11: begin
               writeu_d = 1'b1;
               state_d  = LOWER;
            end
            2'b10:   writeu_d = 1'b1;
            2'b01:   writel_d = 1'b1;
            default: ;
         endcase
      end else if (!fifo_empty) begin
         reg4_write_d = 1'b1;
         reg4_addr_d  = fifo_head.addr;
         reg4_bus_d   = fifo_head.data;
         fifo_pop     = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         writeu_q     <= 1'b0;
         writel_q     <= 1'b0;
         reg4_write_q <= 1'b0;
         reg3_addr_q  <= '0;
         reg3_bus_q   <= '0;
         reg4_addr_q  <= '0;
         reg4_bus_q   <= '0;
      end else begin
         state_q      <= state_d;
         writeu_q     <= writeu_d;
         writel_q     <= writel_d;
         reg4_write_q <= reg4_write_d;
         reg3_addr_q  <= reg3_addr_d;
         reg3_bus_q   <= reg3_bus_d;
         reg4_addr_q  <= reg4_addr_d;
         reg4_bus_q   <= reg4_bus_d;
      end
   end

   assign reg3_writeu = writeu_q;
   assign reg3_writel = writel_q;
   assign reg3_addr   = reg3_addr_q;
   assign reg3_bus    = reg3_bus_q;
   assign reg4_write  = reg4_write_q;
   assign reg4_addr   = reg4_addr_q;
   assign reg4_bus    = reg4_bus_q;

`ifdef WB_HAZARD_EN
   // Strobes on the outputs count as pending: those writes land at the next edge.
   for (genvar gi = 0; gi < A_DEPTH; gi++) begin : g_hit
      assign fifo_hit[gi] = ent_valid[gi] && (ent_addr[gi] == hz_addr);
   end
   assign hz_pending = (|fifo_hit)
                    || ((state_q == LOWER || writeu_q || writel_q) && (reg3_addr_q == hz_addr))
                    || (reg4_write_q && (reg4_addr_q == hz_addr));
`endif

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Scoreboarded bench for reg_write_sequencer: accepted requests queue expected strobes,
// observed strobes pop and compare; directed checks cover handshakes and cycle timing.
module tb_reg_write_sequencer;

   typedef struct packed {
      logic        upper;
      logic [3:0]  addr;
      logic [15:0] data;
   } dexp_t;

   typedef struct packed {
      logic [3:0]  addr;
      logic [15:0] data;
   } aexp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        d_valid, d_ready;
   logic [3:0]  d_addr;
   logic [1:0]  d_mask;
   logic [15:0] d_data;
   logic        a_valid, a_ready;
   logic [3:0]  a_addr;
   logic [15:0] a_data;
   logic        reg3_writeu, reg3_writel, reg4_write;
   logic [3:0]  reg3_addr, reg4_addr;
   logic [15:0] reg3_bus, reg4_bus;
`ifdef WB_HAZARD_EN
   logic [3:0]  hz_addr;
   logic        hz_pending;
`endif

   int    n_cmp = 0;
   int    n_bad = 0;
   dexp_t dq[$];
   aexp_t aq[$];

   reg_write_sequencer #(.A_DEPTH(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .d_valid     (d_valid),
      .d_ready     (d_ready),
      .d_addr      (d_addr),
      .d_mask      (d_mask),
      .d_data      (d_data),
      .a_valid     (a_valid),
      .a_ready     (a_ready),
      .a_addr      (a_addr),
      .a_data      (a_data),
      .reg3_writeu (reg3_writeu),
      .reg3_writel (reg3_writel),
      .reg3_addr   (reg3_addr),
      .reg3_bus    (reg3_bus),
      .reg4_write  (reg4_write),
      .reg4_addr   (reg4_addr),
      .reg4_bus    (reg4_bus)
`ifdef WB_HAZARD_EN
      ,
      .hz_addr     (hz_addr),
      .hz_pending  (hz_pending)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic push_a(input logic [3:0] ad, input logic [15:0] dt);
      int n = 0;
      nxt();
      a_valid = 1'b1;
      a_addr  = ad;
      a_data  = dt;
      smp();
      while (!a_ready && n < 16) begin
         nxt();
         smp();
         n++;
      end
      check("push_a_ready", a_ready, 1);
   endtask

   // Scoreboard: compare strobes first, then queue whatever was accepted this cycle.
   always @(negedge clk) begin
      dexp_t de;
      aexp_t ae;
      if (reg3_writeu || reg3_writel || reg4_write)
         check("one_hot", 32'(reg3_writeu) + 32'(reg3_writel) + 32'(reg4_write), 1);
      if (reg3_writeu || reg3_writel) begin
         check("d_expected", 32'(dq.size() != 0), 1);
         if (dq.size() != 0) begin
            de = dq.pop_front();
            check("d_upper", reg3_writeu, de.upper);
            check("d_addr", reg3_addr, de.addr);
            check("d_bus", reg3_bus, de.data);
         end
      end
      if (reg4_write) begin
         check("a_expected", 32'(aq.size() != 0), 1);
         if (aq.size() != 0) begin
            ae = aq.pop_front();
            check("a_addr", reg4_addr, ae.addr);
            check("a_bus", reg4_bus, ae.data);
         end
      end
      if (rst) begin
         dq.delete();
         aq.delete();
      end else begin
         if (d_valid && d_ready) begin
            if (d_mask[1]) dq.push_back('{upper: 1'b1, addr: d_addr, data: d_data});
            if (d_mask[0]) dq.push_back('{upper: 1'b0, addr: d_addr, data: d_data});
            $display("D accept addr=%0h mask=%0b data=%04h", d_addr, d_mask, d_data);
         end
         if (a_valid && a_ready) begin
            aq.push_back('{addr: a_addr, data: a_data});
            $display("A push   addr=%0h data=%04h", a_addr, a_data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; d_valid = 1'b0; d_addr = '0; d_mask = '0; d_data = '0;
      a_valid = 1'b0; a_addr = '0; a_data = '0;
`ifdef WB_HAZARD_EN
      hz_addr = '0;
`endif
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      smp();
      check("rst_writeu", reg3_writeu, 0);
      check("rst_writel", reg3_writel, 0);
      check("rst_write4", reg4_write, 0);
      check("rst_addr3", reg3_addr, 0);
      check("rst_bus3", reg3_bus, 0);
      check("rst_addr4", reg4_addr, 0);
      check("rst_bus4", reg4_bus, 0);
      check("rst_a_ready", a_ready, 1);

      // Mask 11 then a held mask-01 request: upper at N+1, lower at N+2.
      nxt(); d_valid = 1'b1; d_addr = 4'd5; d_mask = 2'b11; d_data = 16'hA55A;
      smp(); check("t1_rdy_c0", d_ready, 1);
      nxt(); d_addr = 4'd6; d_mask = 2'b01; d_data = 16'h0033;
      smp();
      check("t1_u_c1", reg3_writeu, 1);
      check("t1_l_c1", reg3_writel, 0);
      check("t1_addr_c1", reg3_addr, 5);
      check("t1_bus_c1", reg3_bus, 16'hA55A);
      check("t1_rdy_c1", d_ready, 0);
      nxt(); smp();
      check("t1_l_c2", reg3_writel, 1);
      check("t1_addr_c2", reg3_addr, 5);
      check("t1_rdy_c2", d_ready, 1);
      nxt(); d_valid = 1'b0; smp();
      check("t1_l_c3", reg3_writel, 1);
      check("t1_addr_c3", reg3_addr, 6);
      check("t1_bus_c3", reg3_bus, 16'h0033);
      repeat (3) nxt();

      // Full FIFO pre-empts a waiting data-path request.
      nxt(); d_valid = 1'b1; d_addr = 4'd2; d_mask = 2'b11; d_data = 16'hBEEF;
      a_valid = 1'b1; a_addr = 4'd1; a_data = 16'h1000;
      smp(); check("t2_rdy_c0", d_ready, 1);
      nxt(); d_addr = 4'd3; d_mask = 2'b01; d_data = 16'h0077; a_addr = 4'd4; a_data = 16'h2000;
      smp(); check("t2_rdy_c1", d_ready, 0); check("t2_ardy_c1", a_ready, 1);
      nxt(); a_valid = 1'b0;
      smp(); check("t2_rdy_c2", d_ready, 0); check("t2_ardy_c2", a_ready, 0);
      nxt(); smp();
      check("t2_w4_c3", reg4_write, 1); check("t2_a4_c3", reg4_addr, 1); check("t2_rdy_c3", d_ready, 1);
      nxt(); d_valid = 1'b0; smp();
      check("t2_l_c4", reg3_writel, 1); check("t2_w4_c4", reg4_write, 0);
      nxt(); smp();
      check("t2_w4_c5", reg4_write, 1); check("t2_b4_c5", reg4_bus, 16'h2000);
      repeat (3) nxt();

      // Fill with back-to-back single-byte writes: third push refused while full.
      nxt(); d_valid = 1'b1; d_addr = 4'd8; d_mask = 2'b01; d_data = 16'h0011;
      a_valid = 1'b1; a_addr = 4'd9; a_data = 16'h9001;
      nxt(); a_addr = 4'd10; a_data = 16'h9002;
      nxt(); a_addr = 4'd11; a_data = 16'h9003;
      smp(); check("t3_ardy_full", a_ready, 0); check("t3_rdy_full", d_ready, 0);
      nxt(); smp(); check("t3_ardy_after", a_ready, 1);
      nxt(); d_valid = 1'b0; a_valid = 1'b0;
      repeat (5) nxt();
      for (int i = 0; i < 5; i++) push_a(4'(i + 12), 16'h5000 + 16'(i));
      nxt(); a_valid = 1'b0;
      repeat (4) nxt();

      // Reset while LOWER is pending with one FIFO entry.
      smp(); check("t4_pre_dq", dq.size(), 0); check("t4_pre_aq", aq.size(), 0);
      nxt(); d_valid = 1'b1; d_addr = 4'hC; d_mask = 2'b11; d_data = 16'h1234;
      a_valid = 1'b1; a_addr = 4'hD; a_data = 16'hD00D;
      nxt(); rst = 1'b1; d_valid = 1'b0; a_valid = 1'b0;
      nxt(); rst = 1'b0;
      smp();
      check("t4_strobes", {29'd0, reg3_writeu, reg3_writel, reg4_write}, 0);
      check("t4_addr3", reg3_addr, 0);
      check("t4_bus3", reg3_bus, 0);
      check("t4_addr4", reg4_addr, 0);
      check("t4_bus4", reg4_bus, 0);
      check("t4_a_ready", a_ready, 1);
      repeat (3) nxt();

      // Mask 00 accepted with no strobe; mask 10 drives only the upper strobe.
      nxt(); d_valid = 1'b1; d_addr = 4'd1; d_mask = 2'b00; d_data = 16'hFFFF;
      smp(); check("t5_rdy_00", d_ready, 1);
      nxt(); d_addr = 4'd2; d_mask = 2'b10; d_data = 16'h12FF;
      smp(); check("t5_rdy_10", d_ready, 1);
      check("t5_none", {31'd0, reg3_writeu | reg3_writel}, 0);
      nxt(); d_valid = 1'b0; smp();
      check("t5_u", reg3_writeu, 1); check("t5_l", reg3_writel, 0); check("t5_bus", reg3_bus, 16'h12FF);
      nxt(); smp(); check("t5_l_next", reg3_writel, 0);
      repeat (3) nxt();

`ifdef WB_HAZARD_EN
      nxt(); hz_addr = 4'd7; a_valid = 1'b1; a_addr = 4'd7; a_data = 16'h7777;
      smp(); check("hz_c0", hz_pending, 0);
      nxt(); a_valid = 1'b0; smp(); check("hz_fifo", hz_pending, 1);
      nxt(); smp(); check("hz_strobe", hz_pending, 1); check("hz_w4", reg4_write, 1);
      nxt(); smp(); check("hz_clear", hz_pending, 0);
      repeat (2) nxt();
`endif

      smp();
      check("end_dq_empty", dq.size(), 0);
      check("end_aq_empty", aq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
